// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared funct3 codes, FSM states and decode helpers for the load/store unit
package dmem_lsu_pkg;

  localparam int DATAWIDTH = 32;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_RMW_MERGE = 2'd2
  } lsu_state_e;

  function automatic logic lsu_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    case (f3)
      LSU_B, LSU_H, LSU_W: bad = 1'b0;
      LSU_BU, LSU_HU:      bad = we;
      default:             bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      LSU_H, LSU_HU: mis = off[0];
      LSU_W:         mis = (off != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte/half lane extraction with extension, and sub-word merge into a read word
module dmem_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic [DATAWIDTH-1:0] dob,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [2:0]           funct3,
  input  logic [1:0]           off,
  output logic [DATAWIDTH-1:0] rdata,
  output logic [DATAWIDTH-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^wdata[31:16];

  always_comb begin
    byte_sel = dob[7:0];
    case (off)
      2'd0: byte_sel = dob[7:0];
      2'd1: byte_sel = dob[15:8];
      2'd2: byte_sel = dob[23:16];
      2'd3: byte_sel = dob[31:24];
      default: byte_sel = dob[7:0];
    endcase
    half_sel = off[1] ? dob[31:16] : dob[15:0];

    rdata = '0;
    case (funct3)
      LSU_B:   rdata = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  rdata = {24'b0, byte_sel};
      LSU_H:   rdata = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  rdata = {16'b0, half_sel};
      LSU_W:   rdata = dob;
      default: rdata = '0;
    endcase
  end

  // Only the low two funct3 bits set the access size for stores.
  always_comb begin
    merged = dob;
    if (funct3[1:0] == 2'b00) begin
      case (off)
        2'd0: merged[7:0]   = wdata[7:0];
        2'd1: merged[15:8]  = wdata[7:0];
        2'd2: merged[23:16] = wdata[7:0];
        2'd3: merged[31:24] = wdata[7:0];
        default: merged = dob;
      endcase
    end else if (funct3[1:0] == 2'b01) begin
      if (off[1]) merged[31:16] = wdata[15:0];
      else        merged[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I load/store unit in front of a word-wide dmem without byte enables
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DMADDRWIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [DATAWIDTH-1:0]   req_wdata,
  output logic                   rsp_valid,
  output logic [DATAWIDTH-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   dm_ena,
  output logic                   dm_wea,
  output logic [DMADDRWIDTH-1:0] dm_addra,
  output logic [DATAWIDTH-1:0]   dm_dia,
  output logic                   dm_enb,
  output logic [DMADDRWIDTH-1:0] dm_addrb,
  input  logic [DATAWIDTH-1:0]   dm_dob
);

  lsu_state_e             state_q, state_d;
  logic [2:0]             f3_q, f3_d;
  logic [1:0]             off_q, off_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic [DMADDRWIDTH-1:0] waddr_q, waddr_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [DATAWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [DMADDRWIDTH-1:0] req_waddr;
  logic                   req_bad;
  logic                   ena_c, enb_c;
  logic [DMADDRWIDTH-1:0] addra_c;
  logic [DATAWIDTH-1:0]   dia_c;
  logic [DATAWIDTH-1:0]   align_rdata, align_merged;
  logic                   unused_addr_hi;

  assign req_waddr      = req_addr[DMADDRWIDTH+1:2];
  assign unused_addr_hi = ^req_addr[31:DMADDRWIDTH+2];
  assign req_bad        = lsu_illegal(req_we, req_funct3) || lsu_misaligned(req_funct3, req_addr[1:0]);

  // Fed from latched request fields: both LOAD_WAIT and RMW_MERGE work on the word read last cycle.
  dmem_lane_align u_align (
    .dob    (dm_dob),
    .wdata  (wdata_q),
    .funct3 (f3_q),
    .off    (off_q),
    .rdata  (align_rdata),
    .merged (align_merged)
  );

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    ena_c       = 1'b0;
    enb_c       = 1'b0;
    addra_c     = waddr_q;
    dia_c       = align_merged;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && req_funct3 == LSU_W) begin
            ena_c       = 1'b1;
            addra_c     = req_waddr;
            dia_c       = req_wdata;
            rsp_valid_d = 1'b1;
          end else begin
            enb_c   = 1'b1;
            f3_d    = req_funct3;
            off_d   = req_addr[1:0];
            waddr_d = req_waddr;
            if (req_we) begin
              wdata_d = req_wdata;
              state_d = ST_RMW_MERGE;
            end else begin
              state_d = ST_LOAD_WAIT;
            end
          end
        end
      end
      ST_LOAD_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = align_rdata;
        state_d     = ST_IDLE;
      end
      ST_RMW_MERGE: begin
        ena_c       = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Gating with rst_n keeps an in-flight merge from writing while reset is held.
  assign dm_ena    = ena_c & rst_n;
  assign dm_wea    = ena_c & rst_n;
  assign dm_enb    = enb_c & rst_n;
  assign dm_addra  = addra_c;
  assign dm_dia    = dia_c;
  assign dm_addrb  = req_waddr;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
